uart_div_frame_ctrl: RTL and testbench
======================================

// Module: uart_div_frame_ctrl
// PURPOSE
//   Frame controller between uart_rx/uart_tx byte engines and the LED driver.
//   Receives dividend A and divisor B as byte streams, divides with a
//   sequential restoring divider, then returns quotient Y and remainder R as
//   paced TX bytes. Y is also shown on the LEDs. Width, pacing and timeout are
//   parametrised; adds divide-by-zero and frame-timeout handling.
// PARAMETERS
//   DATA_W      16      operand width in bits; multiple of 8, 8..32; NB = DATA_W/8
//   GAP_CNT     166576  clk cycles between successive tx_valid pulses (>=2)
//   RX_TIMEOUT  2000000 idle clk cycles mid-frame before the frame is dropped (>=2)
//   LED_W       24      y_to_led width; >= DATA_W
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   rst        in   1       synchronous active-low reset
//   rx_valid   in   1       one-cycle strobe: rx_data holds a received byte
//   rx_data    in   8       received byte
//   tx_busy    in   1       uart_tx busy; no tx_valid issued while high
//   tx_valid   out  1       one-cycle strobe: tx_data is to be sent
//   tx_data    out  8       byte to send; held stable until next tx_valid
//   y_to_led   out  LED_W   last quotient, zero-extended
//   busy       out  1       high in every state except IDLE
//   div0       out  1       sticky: last frame had B==0; cleared at next frame's first byte
//   frame_err  out  1       one-cycle pulse when a partial frame is dropped
// BEHAVIOUR
//   Reset (rst==0 at posedge): all outputs 0, state IDLE, counters/byte index 0,
//     A/B/Y/R 0. Reset wins over every event, including mid-frame and mid-TX.
//   FSM: IDLE -> RX_A -> RX_B -> DIV -> TX -> IDLE.
//   IDLE: first rx_valid stores byte into A[7:0], moves to RX_A (idx=1). If NB==1,
//     goes straight to RX_B.
//   RX_A/RX_B: byte k of an operand goes to bits [8k+7:8k] (little-endian,
//     LSB first). After byte NB-1 of A go RX_B; after byte NB-1 of B go DIV.
//   Timeout: idle counter cleared on every rx_valid, incremented otherwise in
//     RX_A/RX_B. At RX_TIMEOUT-1 -> frame_err pulse, A/B cleared, IDLE.
//     A rx_valid in the same cycle as expiry is taken as a byte; no timeout.
//   DIV: exactly DATA_W cycles, one quotient bit per cycle, MSB first, with a
//     DATA_W+1-bit partial remainder. Then Y and R are loaded, y_to_led<=Y, go TX.
//     If B==0: Y=all ones, R=A, div0<=1; same DATA_W-cycle latency.
//   TX: sends 2*NB bytes: Y LSB..MSB, then R LSB..MSB.
//     The gap counter starts at 0 on entry and saturates at GAP_CNT-1.
//     A byte is issued (tx_valid=1, tx_data=byte) when the counter is at
//     GAP_CNT-1 and tx_busy==0. The counter then returns to 0.
//     A high tx_busy at expiry holds the byte; no byte is skipped or repeated.
//     After the last byte, return to IDLE on the next cycle.
//   rx_valid in DIV or TX is ignored: no state change, no error.
//   Width rules: all arithmetic is unsigned. Y and R are DATA_W bits. y_to_led
//     upper LED_W-DATA_W bits are 0.
// TESTING (DATA_W=16, GAP_CNT=4, RX_TIMEOUT=50 unless stated)
//   1 bytes E8,03,07,00 (A=1000,B=7) -> tx 8E,00,06,00 (Y=142,R=6); y_to_led=142;
//     4 tx_valid pulses exactly 4 cycles apart with tx_busy=0
//   2 A=0x1234,B=0 -> div0=1; tx FF,FF,34,12; y_to_led=0x00FFFF; next frame's first byte clears div0
//   3 send 2 bytes, idle 50 cycles -> frame_err one cycle, busy=0;
//     next 4 bytes (A=9,B=2) -> tx 04,00,01,00
//   4 hold tx_busy=1 for 20 cycles around 2nd byte -> byte held, tx_valid fires the
//     first cycle tx_busy=0; all 4 bytes appear in order, none duplicated
//   5 rst=0 for 1 cycle mid-DIV and again mid-TX -> all outputs 0 next cycle;
//     a fresh frame then completes correctly
//   6 DATA_W=8: A=0xFF,B=0x10 -> tx 0F,0F; rx_valid strobes during DIV/TX are ignored

Source files
------------

// File: rtl/uart_div_frame_ctrl.sv
// Frame controller: collects A and B as little-endian byte streams, runs a DATA_W-cycle
// restoring divide, then paces Y and R back out as TX bytes; drops stalled partial frames.
module uart_div_frame_ctrl #(
  parameter int DATA_W     = 16,
  parameter int GAP_CNT    = 166576,
  parameter int RX_TIMEOUT = 2000000,
  parameter int LED_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic [LED_W-1:0] y_to_led,
  output logic             busy,
  output logic             div0,
  output logic             frame_err
);

  localparam int NB  = DATA_W / 8;
  localparam int IXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TXW = $clog2(2 * NB);
  localparam int BCW = $clog2(DATA_W);
  localparam int GW  = $clog2(GAP_CNT);
  localparam int TW  = $clog2(RX_TIMEOUT);

  localparam logic [IXW-1:0] IX_LAST = IXW'(NB - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(2 * NB - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_W - 1);
  localparam logic [GW-1:0]  G_LAST  = GW'(GAP_CNT - 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RX_A, RX_B, DIV, TX} state_t;

  state_t              state;
  logic [DATA_W-1:0]   a, b, y, r, rem, quo;
  logic [IXW-1:0]      idx;
  logic [TXW-1:0]      tx_idx;
  logic [BCW-1:0]      bit_cnt;
  logic [GW-1:0]       gap;
  logic [TW-1:0]       idle_cnt;
  logic [DATA_W:0]     trial;
  logic                ge;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;
  logic [2*DATA_W-1:0] txv;

  // The partial remainder is always < B, so only the shifted trial needs the extra bit.
  // With B==0 every step subtracts nothing: Y ends all ones and R ends equal to A.
  always_comb begin
    trial   = {rem, a[DATA_W-1]};
    ge      = (trial >= {1'b0, b});
    rem_nxt = ge ? DATA_W'(trial - {1'b0, b}) : trial[DATA_W-1:0];
    quo_nxt = {quo[DATA_W-2:0], ge};
  end

  assign txv  = {r, y};
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      y         <= '0;
      r         <= '0;
      rem       <= '0;
      quo       <= '0;
      idx       <= '0;
      tx_idx    <= '0;
      bit_cnt   <= '0;
      gap       <= '0;
      idle_cnt  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      y_to_led  <= '0;
      div0      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            a        <= DATA_W'(rx_data);
            b        <= '0;
            div0     <= 1'b0;
            idle_cnt <= '0;
            if (NB == 1) begin
              state <= RX_B;
              idx   <= '0;
            end else begin
              state <= RX_A;
              idx   <= IXW'(1);
            end
          end
        end
        RX_A, RX_B: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (state == RX_A) a[8*idx +: 8] <= rx_data;
            else               b[8*idx +: 8] <= rx_data;
            if (idx == IX_LAST) begin
              idx <= '0;
              if (state == RX_A) begin
                state <= RX_B;
              end else begin
                state   <= DIV;
                rem     <= '0;
                quo     <= '0;
                bit_cnt <= '0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (idle_cnt == T_LAST) begin
            frame_err <= 1'b1;
            a         <= '0;
            b         <= '0;
            idx       <= '0;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DIV: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          a       <= {a[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BC_LAST) begin
            y        <= quo_nxt;
            r        <= rem_nxt;
            y_to_led <= LED_W'(quo_nxt);
            div0     <= (b == '0);
            state    <= TX;
            gap      <= '0;
            tx_idx   <= '0;
          end
        end
        TX: begin
          // Counter parks at its last value while tx_busy holds the pending byte.
          if (gap == G_LAST) begin
            if (!tx_busy) begin
              tx_valid <= 1'b1;
              tx_data  <= txv[8*tx_idx +: 8];
              gap      <= '0;
              tx_idx   <= tx_idx + 1'b1;
              if (tx_idx == TX_LAST) state <= IDLE;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_div_frame_ctrl.sv
// Scoreboard bench for uart_div_frame_ctrl: a 16-bit and an 8-bit instance driven with
// directed and random frames; expected TX bytes come from plain integer division.
module tb_uart_div_frame_ctrl;

  localparam int GAP = 4;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        tx_busy  = 1'b0;
  logic        tx_valid, busy, div0, frame_err;
  logic [7:0]  tx_data;
  logic [23:0] y_to_led;

  logic        rx_valid_8 = 1'b0;
  logic [7:0]  rx_data_8  = 8'h00;
  logic        tx_busy_8  = 1'b0;
  logic        tx_valid_8, busy_8, div0_8, frame_err_8;
  logic [7:0]  tx_data_8;
  logic [23:0] y_to_led_8;

  uart_div_frame_ctrl #(.DATA_W(16), .GAP_CNT(GAP), .RX_TIMEOUT(TO), .LED_W(24)) dut16 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(tx_valid), .tx_data(tx_data), .y_to_led(y_to_led), .busy(busy),
    .div0(div0), .frame_err(frame_err));

  uart_div_frame_ctrl #(.DATA_W(8), .GAP_CNT(GAP), .RX_TIMEOUT(TO), .LED_W(24)) dut8 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_8), .rx_data(rx_data_8), .tx_busy(tx_busy_8),
    .tx_valid(tx_valid_8), .tx_data(tx_data_8), .y_to_led(y_to_led_8), .busy(busy_8),
    .div0(div0_8), .frame_err(frame_err_8));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ferr_cnt_8 = 0;
  logic [7:0]  q16[$];
  logic [7:0]  q8[$];
  logic        rnd_busy = 1'b0;
  logic [15:0] exp_y16 = '0;
  logic        exp_div0_16 = 1'b0;
  logic [7:0]  exp_y8 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected byte per tx_valid; spacing is checked only when tx_busy
  // stayed low for the whole interval since the previous byte of the same frame.
  int   n16 = 0, last16 = 0, n8 = 0, last8 = 0;
  logic bseen16 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      n16 = 0;
      bseen16 = 1'b0;
    end else begin
      if (tx_valid) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx16_unexpected: got byte 0x%0h, expected no byte", tx_data);
        end else begin
          check("tx16_byte", 32'(tx_data), 32'(q16.pop_front()));
        end
        if (n16 != 0 && !bseen16) check("tx16_gap", 32'(cyc - last16), GAP);
        n16 = (n16 + 1) % 4;
        last16 = cyc;
        bseen16 = 1'b0;
      end
      if (tx_busy) bseen16 = 1'b1;
      if (frame_err) ferr_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n8 = 0;
    end else begin
      if (tx_valid_8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx8_unexpected: got byte 0x%0h, expected no byte", tx_data_8);
        end else begin
          check("tx8_byte", 32'(tx_data_8), 32'(q8.pop_front()));
        end
        if (n8 != 0) check("tx8_gap", 32'(cyc - last8), GAP);
        n8 = (n8 + 1) % 2;
        last8 = cyc;
      end
      if (frame_err_8) ferr_cnt_8++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [7:0] v);
    rx_data = v; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y, r;
    y = (b == 0) ? 16'hFFFF : a / b;
    r = (b == 0) ? a : a % b;
    q16.push_back(y[7:0]); q16.push_back(y[15:8]);
    q16.push_back(r[7:0]); q16.push_back(r[15:8]);
    exp_y16 = y;
    exp_div0_16 = (b == 0);
  endtask

  task automatic frame16(input logic [15:0] a, input logic [15:0] b, input int maxgap);
    push16(a, b);
    send16(a[7:0]);  repeat ($urandom_range(0, maxgap)) tick();
    send16(a[15:8]); repeat ($urandom_range(0, maxgap)) tick();
    send16(b[7:0]);  repeat ($urandom_range(0, maxgap)) tick();
    send16(b[15:8]);
  endtask

  task automatic wait16(input string name);
    int n = 0;
    while ((q16.size() != 0 || busy) && n < 2000) begin
      if (rnd_busy) tx_busy = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    tx_busy = 1'b0;
    check({name, "_done"}, 32'(n < 2000), 1);
    check({name, "_led"}, 32'(y_to_led), 32'(exp_y16));
    check({name, "_div0"}, 32'(div0), 32'(exp_div0_16));
  endtask

  task automatic wait_tx16(input string name);
    int n = 0;
    while (!tx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_tx_seen"}, 32'(n < 500), 1);
  endtask

  task automatic send8(input logic [7:0] v);
    rx_data_8 = v; rx_valid_8 = 1'b1;
    tick();
    rx_valid_8 = 1'b0;
  endtask

  task automatic frame8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y, r;
    y = (b == 0) ? 8'hFF : a / b;
    r = (b == 0) ? a : a % b;
    q8.push_back(y); q8.push_back(r);
    exp_y8 = y;
    send8(a); repeat ($urandom_range(0, 3)) tick();
    send8(b);
  endtask

  // Random rx strobes are injected only while the 8-bit instance is busy (DIV/TX).
  task automatic wait8(input string name);
    int n = 0;
    while ((q8.size() != 0 || busy_8) && n < 2000) begin
      if (busy_8) begin
        rx_valid_8 = 1'($urandom_range(0, 1));
        rx_data_8  = 8'($urandom);
      end else begin
        rx_valid_8 = 1'b0;
      end
      tick();
      n++;
    end
    rx_valid_8 = 1'b0;
    check({name, "_done"}, 32'(n < 2000), 1);
    check({name, "_led"}, 32'(y_to_led_8), 32'(exp_y8));
  endtask

  task automatic pulse_rst(input string name);
    rst = 1'b0;
    tick();
    check({name, "_tx_valid"}, 32'(tx_valid), 0);
    check({name, "_tx_data"}, 32'(tx_data), 0);
    check({name, "_led"}, 32'(y_to_led), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_div0"}, 32'(div0), 0);
    check({name, "_frame_err"}, 32'(frame_err), 0);
    rst = 1'b1;
    q16.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    logic [15:0] ra, rb;
    logic [7:0]  a8, b8;

    repeat (3) tick();
    pulse_rst("reset");

    // Basic divide with exact pacing.
    frame16(16'd1000, 16'd7, 3);
    wait16("t1");
    check("t1_led_142", 32'(y_to_led), 142);

    // Divide by zero, then the next frame's first byte clears div0.
    frame16(16'h1234, 16'h0000, 2);
    wait16("t2");
    check("t2_led_ffff", 32'(y_to_led), 32'h00FFFF);

    // Stalled partial frame: timeout lands exactly TO idle cycles after the last byte.
    f0 = ferr_cnt;
    send16(8'h11);
    check("t2_div0_cleared", 32'(div0), 0);
    send16(8'h22);
    repeat (TO - 1) tick();
    check("t3_no_err_early", 32'(frame_err), 0);
    check("t3_busy_early", 32'(busy), 1);
    tick();
    check("t3_frame_err", 32'(frame_err), 1);
    check("t3_busy_after", 32'(busy), 0);
    tick();
    check("t3_err_one_cycle", 32'(frame_err), 0);
    check("t3_err_count", 32'(ferr_cnt - f0), 1);
    frame16(16'd9, 16'd2, 3);
    wait16("t3");

    // A byte arriving in the expiry cycle is accepted, not timed out.
    f0 = ferr_cnt;
    push16(16'd5000, 16'd51);
    send16(8'h88); send16(8'h13);
    repeat (TO - 1) tick();
    send16(8'h33);
    repeat (TO - 1) tick();
    send16(8'h00);
    wait16("edge");
    check("edge_no_err", 32'(ferr_cnt - f0), 0);

    // tx_busy held across the second byte: byte waits and fires on the first free cycle.
    frame16(16'hBEEF, 16'h0123, 0);
    wait_tx16("t4");
    tick();
    tx_busy = 1'b1;
    repeat (20) tick();
    check("t4_held", 32'(tx_valid), 0);
    tx_busy = 1'b0;
    tick();
    check("t4_release", 32'(tx_valid), 1);
    wait16("t4");

    // Reset mid-DIV and mid-TX, then a clean frame.
    frame16(16'h4321, 16'h0005, 0);
    repeat (5) tick();
    check("t5_in_div", 32'(busy), 1);
    pulse_rst("rst_div");
    frame16(16'hABCD, 16'h0011, 0);
    wait_tx16("t5");
    tick();
    pulse_rst("rst_tx");
    frame16(16'd60000, 16'd123, 2);
    wait16("t5");

    // Random frames with random tx_busy back-pressure.
    rnd_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      frame16(ra, rb, 5);
      wait16("rnd");
    end
    rnd_busy = 1'b0;

    // 8-bit instance, with strobes during DIV/TX that must be ignored.
    frame8(8'hFF, 8'h10);
    wait8("t6");
    check("t6_led_0f", 32'(y_to_led_8), 32'h0F);
    for (int i = 0; i < 6; i++) begin
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      frame8(a8, b8);
      wait8("rnd8");
    end

    check("frame_err_total", 32'(ferr_cnt), 1);
    check("frame_err_total_8", 32'(ferr_cnt_8), 0);
    check("q16_drained", 32'(q16.size()), 0);
    check("q8_drained", 32'(q8.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
